sreg_unit: RTL
==============

# sreg_unit

Status-register and result-writeback stage directly downstream of the CPU ALU. It does three things:
- Captures the ALU flag outputs into the AVR SREG (I T H S V N Z C) under per-instruction update masks.
- Executes the flag-only instructions BSET, BCLR, BST and OUT SREG, plus interrupt entry and RETI.
- Registers the ALU result for register-file writeback, and forwards that pending result back to operand fetch.

It returns the registered carry as the ALU carry input for the next instruction.

## Interface
Parameters:
- RST_SREG, 8'h00, SREG value loaded at reset.
- SREG_IO, 6'h3F, I/O address that maps to SREG.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold; freezes all state except I-flag interrupt entry.
- alu_cf, alu_zf, alu_nf, alu_vf, alu_sf, alu_hf  in  1 each  flags from the ALU.
- upd_mask  in  6  flag update enables; bit0 C, 1 Z, 2 N, 3 V, 4 S, 5 H.
- z_chain  in  1  SBC/SBCI/CPC Z rule: new Z = old Z & alu_zf.
- bset, bclr  in  1  set / clear SREG bit bsel.
- bsel  in  3  bit index for BSET/BCLR.
- bst  in  1  BST: T <= bst_val.
- bst_val  in  1  selected Rd bit, prepared upstream.
- io_we  in  1  I/O write strobe.
- io_addr  in  6  I/O address.
- io_wdata  in  8  I/O write data.
- int_ack  in  1  interrupt entry; clears I.
- reti  in  1  RETI; sets I.
- alu_ro  in  16  ALU result.
- wb_en  in  1  result is to be written back.
- wb_word  in  1  16-bit result, written to a register pair.
- wb_addr  in  5  destination register; must be even when wb_word=1.
- rs_a, rs_b  in  5  source register addresses being fetched.
- sreg  out  8  registered SREG.
- ci  out  1  sreg[0], wired to the ALU carry input.
- wb_we_o  out  1  registered writeback enable.
- wb_word_o  out  1  registered word flag.
- wb_addr_o  out  5  registered destination address.
- wb_data_o  out  16  registered result.
- fwd_a, fwd_b  out  1  pending writeback matches rs_a / rs_b.
- fwd_da, fwd_db  out  8  forwarded byte for rs_a / rs_b.

## Operation
- Reset (async, rst_n low):
  - sreg <= RST_SREG.
  - wb_we_o, wb_word_o, wb_addr_o, wb_data_o <= 0.
  - The forwarding outputs therefore read 0.
- The next SREG value is built from the current sreg. Steps apply in this order; a later step overrides an earlier one.
  1. ALU capture. For each flag bit k with upd_mask[k]=1, load the matching alu_* flag. For Z with z_chain=1, load sreg[1] & alu_zf instead.
  2. If bset, bit bsel <= 1. If bclr, bit bsel <= 0. If both are asserted, bclr wins.
  3. If bst, T (bit6) <= bst_val.
  4. If io_we and io_addr==SREG_IO, the whole SREG <= io_wdata.
  5. If reti, I (bit7) <= 1.
  6. If int_ack, I <= 0. int_ack beats reti and all earlier steps.
- Steps 1–5 apply only when stall=0. int_ack applies even when stall=1.
- Writeback register, when stall=0:
  - wb_we_o <= wb_en.
  - wb_word_o <= wb_en & wb_word.
  - wb_addr_o <= wb_addr.
  - wb_data_o <= alu_ro.
  - When stall=1 all four hold their values.
- Byte writeback writes wb_data_o[7:0] to wb_addr_o.
- Word writeback writes the low byte to wb_addr_o and the high byte to wb_addr_o|1.
- Forwarding is combinational from the registered state and rs_x:
  - fwd_x = wb_we_o & (rs_x==wb_addr_o | (wb_word_o & rs_x==(wb_addr_o|1))).
  - fwd_dx = wb_data_o[15:8] if rs_x is the odd half of a word write; wb_data_o[7:0] if fwd_x on any other match; 0 if fwd_x=0.
- A wb_word with an odd wb_addr is illegal and does not need to be detected.

## Timing
- All state updates on the rising clk edge.
- Latency of one cycle:
  - SREG and ci reflect an instruction's flags one cycle after it is presented.
  - wb_*_o are valid the cycle after wb_en.
- ci is registered. An ADC/SBC in the cycle right after a flag-writing instruction sees the updated C.
- Forwarding outputs settle within the same cycle as rs_a / rs_b. There is no extra latency.
- Reset mid-operation clears a pending writeback immediately (asynchronous). No register write occurs after reset release until a new wb_en.

## Test plan
- Reset: drive rst_n=0 mid-cycle with state loaded -> sreg=8'h00, wb_we_o=0, fwd_a=0 immediately, without waiting for a clk edge.
- ALU capture, masked: upd_mask=6'b111111, flags C=1 Z=0 N=1 V=0 S=1 H=1 -> sreg=8'h35. Then upd_mask=6'b000001 with all flags 0 -> sreg=8'h34.
- Z chain: start Z=1. Apply z_chain with alu_zf=1 -> Z=1. Apply z_chain with alu_zf=1 on a start Z=0 -> Z stays 0.
- Priority:
  - Same cycle: io_we to 6'h3F with 8'h00, reti, int_ack -> sreg=8'h00 (I=0).
  - Same cycle: reti alone with io_wdata 8'h01 -> sreg=8'h81.
  - stall=1 with upd_mask set plus int_ack -> only I cleared.
- Word writeback and forwarding: wb_en, wb_word, wb_addr=24, alu_ro=16'hBEEF. Next cycle:
  - rs_a=25 -> fwd_a=1, fwd_da=8'hBE.
  - rs_b=24 -> fwd_db=8'hEF.
  - rs_a=26 -> fwd_a=0.
- Stall hold: wb_en with alu_ro=16'h0012, then stall=1 for 3 cycles with new alu_ro=16'h0099 -> wb_data_o stays 16'h0012 until stall drops.

Source files
------------

// File: rtl/sreg_unit.sv
// AVR status register (SREG) update plus one-entry ALU result writeback stage.
// The pending writeback is forwarded combinationally to operand fetch.
module sreg_unit #(
  parameter logic [7:0] RST_SREG = 8'h00,
  parameter logic [5:0] SREG_IO  = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        alu_cf,
  input  logic        alu_zf,
  input  logic        alu_nf,
  input  logic        alu_vf,
  input  logic        alu_sf,
  input  logic        alu_hf,
  input  logic [5:0]  upd_mask,
  input  logic        z_chain,
  input  logic        bset,
  input  logic        bclr,
  input  logic [2:0]  bsel,
  input  logic        bst,
  input  logic        bst_val,
  input  logic        io_we,
  input  logic [5:0]  io_addr,
  input  logic [7:0]  io_wdata,
  input  logic        int_ack,
  input  logic        reti,
  input  logic [15:0] alu_ro,
  input  logic        wb_en,
  input  logic        wb_word,
  input  logic [4:0]  wb_addr,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  output logic [7:0]  sreg,
  output logic        ci,
  output logic        wb_we_o,
  output logic        wb_word_o,
  output logic [4:0]  wb_addr_o,
  output logic [15:0] wb_data_o,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [7:0]  fwd_da,
  output logic [7:0]  fwd_db
);

  logic [7:0]  sreg_q, sreg_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_word_q, wb_word_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [5:0]  alu_flags;

  assign alu_flags = {alu_hf, alu_sf, alu_vf, alu_nf, alu_zf, alu_cf};

  // Later steps deliberately overwrite earlier ones; int_ack sits outside the stall gate.
  always_comb begin
    sreg_d = sreg_q;
    if (!stall) begin
      for (int unsigned k = 0; k < 6; k++) begin
        if (upd_mask[k]) sreg_d[k] = alu_flags[k];
      end
      if (upd_mask[1] && z_chain) sreg_d[1] = sreg_q[1] & alu_zf;
      if (bset) sreg_d[bsel] = 1'b1;
      if (bclr) sreg_d[bsel] = 1'b0;
      if (bst) sreg_d[6] = bst_val;
      if (io_we && io_addr == SREG_IO) sreg_d = io_wdata;
      if (reti) sreg_d[7] = 1'b1;
    end
    if (int_ack) sreg_d[7] = 1'b0;
  end

  always_comb begin
    wb_we_d   = wb_we_q;
    wb_word_d = wb_word_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (!stall) begin
      wb_we_d   = wb_en;
      wb_word_d = wb_en & wb_word;
      wb_addr_d = wb_addr;
      wb_data_d = alu_ro;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q    <= RST_SREG;
      wb_we_q   <= 1'b0;
      wb_word_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      sreg_q    <= sreg_d;
      wb_we_q   <= wb_we_d;
      wb_word_q <= wb_word_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // An exact address match takes the low byte; the odd partner of a word write takes the high byte.
  always_comb begin
    fwd_a  = 1'b0;
    fwd_da = '0;
    fwd_b  = 1'b0;
    fwd_db = '0;
    if (wb_we_q) begin
      if (rs_a == wb_addr_q) begin
        fwd_a  = 1'b1;
        fwd_da = wb_data_q[7:0];
      end else if (wb_word_q && rs_a == (wb_addr_q | 5'd1)) begin
        fwd_a  = 1'b1;
        fwd_da = wb_data_q[15:8];
      end
      if (rs_b == wb_addr_q) begin
        fwd_b  = 1'b1;
        fwd_db = wb_data_q[7:0];
      end else if (wb_word_q && rs_b == (wb_addr_q | 5'd1)) begin
        fwd_b  = 1'b1;
        fwd_db = wb_data_q[15:8];
      end
    end
  end

  assign sreg      = sreg_q;
  assign ci        = sreg_q[0];
  assign wb_we_o   = wb_we_q;
  assign wb_word_o = wb_word_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;

endmodule
